// File: rtl/branch_redirect_ctrl.sv
// Branch resolution and front-end redirect controller: one-cycle redirect/flush on mispredict, then a drain window.
// Define BRANCH_PREDICT_EN to build the 2-bit BHT predictor; without it every fetch predicts not-taken.
module branch_redirect_ctrl #(
   parameter int XLEN         = 32,
   parameter int BHT_ENTRIES  = 16,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   input  logic            ex_valid,
   input  logic            ex_branch,
   input  logic            ex_taken,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_target,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush,
   output logic            busy,
   output logic [15:0]     mispredict_cnt
);
   localparam int IDXW = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;
   localparam int DCW  = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

   state_t          state_q, state_d;
   logic [DCW-1:0]  drain_q, drain_d;
   logic            redirect_valid_q, redirect_valid_d;
   logic            flush_q, flush_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic [15:0]     mispredict_cnt_q, mispredict_cnt_d;
   logic            resolve, mispredict;
   logic            unused_if;

   // EX results are only trusted while IDLE; anything seen in REDIRECT/DRAIN is wrong-path.
   assign resolve    = ex_valid & ex_branch & (state_q == IDLE);
   assign mispredict = resolve & (ex_taken != ex_pred_taken);
   assign unused_if  = ^{if_valid, if_pc};

   always_comb begin
      state_d          = state_q;
      drain_d          = drain_q;
      redirect_pc_d    = redirect_pc_q;
      mispredict_cnt_d = mispredict_cnt_q;
      case (state_q)
         IDLE: begin
            if (mispredict) begin
               state_d       = REDIRECT;
               redirect_pc_d = ex_taken ? ex_target : ex_pc + XLEN'(4);
            end
         end
         REDIRECT: begin
            state_d = DRAIN;
            drain_d = DCW'(DRAIN_CYCLES);
         end
         DRAIN: begin
            if (drain_q == DCW'(1)) state_d = IDLE;
            else                    drain_d = drain_q - DCW'(1);
         end
         default: state_d = IDLE;
      endcase
      if (mispredict && (mispredict_cnt_q != 16'hFFFF))
         mispredict_cnt_d = mispredict_cnt_q + 16'd1;
      redirect_valid_d = (state_d == REDIRECT);
      flush_d          = (state_d == REDIRECT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         drain_q          <= '0;
         redirect_valid_q <= 1'b0;
         flush_q          <= 1'b0;
         redirect_pc_q    <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         state_q          <= state_d;
         drain_q          <= drain_d;
         redirect_valid_q <= redirect_valid_d;
         flush_q          <= flush_d;
         redirect_pc_q    <= redirect_pc_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign flush          = flush_q;
   assign redirect_pc    = redirect_pc_q;
   assign mispredict_cnt = mispredict_cnt_q;
   assign busy           = (state_q != IDLE);

`ifdef BRANCH_PREDICT_EN
   logic [1:0]      bht_q [BHT_ENTRIES];
   logic [1:0]      bht_d [BHT_ENTRIES];
   logic [IDXW-1:0] if_idx, ex_idx;

   assign if_idx = if_pc[2 +: IDXW];
   assign ex_idx = ex_pc[2 +: IDXW];
   // Reads come straight from the flops, so a same-cycle update to this index is not yet visible.
   assign pred_taken = if_valid & bht_q[if_idx][1];

   always_comb begin
      bht_d = bht_q;
      if (resolve) begin
         if (ex_taken && (bht_q[ex_idx] != 2'b11))
            bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
         else if (!ex_taken && (bht_q[ex_idx] != 2'b00))
            bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      end else begin
         bht_q <= bht_d;
      end
   end
`else
   assign pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: redirect sequencing, pc wrap, drain drop, predictor and reset abort.
module tb_branch_redirect_ctrl;
   localparam int XLEN = 32;
`ifdef BRANCH_PREDICT_EN
   localparam bit PRED_EN = 1'b1;
`else
   localparam bit PRED_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            if_valid = 1'b0;
   logic [XLEN-1:0] if_pc = '0;
   logic            pred_taken;
   logic            ex_valid = 1'b0;
   logic            ex_branch = 1'b0;
   logic            ex_taken = 1'b0;
   logic            ex_pred_taken = 1'b0;
   logic [XLEN-1:0] ex_pc = '0;
   logic [XLEN-1:0] ex_target = '0;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            flush;
   logic            busy;
   logic [15:0]     mispredict_cnt;

   int vectors = 0;
   int miscompares = 0;

   branch_redirect_ctrl #(.XLEN(XLEN), .BHT_ENTRIES(16), .DRAIN_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .pred_taken(pred_taken),
      .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_taken(ex_taken),
      .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc), .ex_target(ex_target),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
      .busy(busy), .mispredict_cnt(mispredict_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ex(input logic v, input logic br, input logic tk, input logic pt,
                           input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt);
      ex_valid = v; ex_branch = br; ex_taken = tk; ex_pred_taken = pt; ex_pc = pc; ex_target = tgt;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #3;
      @(negedge clk);
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; if_valid = 1'b1; if_pc = 32'h40;
      #3;
      vectors++;
      if ({redirect_valid, flush, busy} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_ctrl rv/flush/busy=%b expected 000", {redirect_valid, flush, busy});
      end
      vectors++;
      if (redirect_pc !== 32'h0 || mispredict_cnt !== 16'h0) begin
         miscompares++;
         $display("FAIL reset_regs redirect_pc=%h cnt=%h expected 0/0", redirect_pc, mispredict_cnt);
      end
      vectors++;
      if (pred_taken !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_pred pred_taken=%b expected 0", pred_taken);
      end
      @(negedge clk);
      rst = 1'b0; if_valid = 1'b0;
      step();
   endtask

   task automatic test_mispredict_taken();
      logic exp_busy [4];
      exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0};
      drive_ex(1, 1, 1, 0, 32'h100, 32'h80);
      step();
      drive_ex(0, 0, 0, 0, 32'h0, 32'h0);
      vectors++;
      if ({redirect_valid, flush} !== 2'b11 || redirect_pc !== 32'h80) begin
         miscompares++;
         $display("FAIL taken_redirect rv/flush=%b pc=%h expected 11/00000080", {redirect_valid, flush}, redirect_pc);
      end
      vectors++;
      if (mispredict_cnt !== 16'd1) begin
         miscompares++;
         $display("FAIL taken_cnt cnt=%0d expected 1", mispredict_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         vectors++;
         if (busy !== exp_busy[i]) begin
            miscompares++;
            $display("FAIL taken_busy cycle %0d busy=%b expected %b", i, busy, exp_busy[i]);
         end
      end
      step();
      vectors++;
      if ({redirect_valid, flush} !== 2'b00) begin
         miscompares++;
         $display("FAIL taken_pulse_len rv/flush=%b expected 00", {redirect_valid, flush});
      end
   endtask

   task automatic test_wrap();
      drive_ex(1, 1, 0, 1, 32'hFFFF_FFFC, 32'h1234);
      step();
      drive_ex(0, 0, 0, 0, 32'h0, 32'h0);
      vectors++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0 || mispredict_cnt !== 16'd2) begin
         miscompares++;
         $display("FAIL wrap rv=%b pc=%h cnt=%0d expected 1/00000000/2", redirect_valid, redirect_pc, mispredict_cnt);
      end
      step(); step(); step();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL wrap_idle busy=%b expected 0", busy);
      end
   endtask

   task automatic test_correct_predict();
      drive_ex(1, 1, 1, 1, 32'h2C, 32'h500);
      step();
      drive_ex(1, 0, 1, 0, 32'h30, 32'h600);
      vectors++;
      if ({redirect_valid, flush, busy} !== 3'b000 || mispredict_cnt !== 16'd2) begin
         miscompares++;
         $display("FAIL correct rv/flush/busy=%b cnt=%0d expected 000/2", {redirect_valid, flush, busy}, mispredict_cnt);
      end
      step();
      ex_branch = 1'b1; ex_valid = 1'b0;
      vectors++;
      if ({redirect_valid, flush, busy} !== 3'b000 || mispredict_cnt !== 16'd2) begin
         miscompares++;
         $display("FAIL non_branch rv/flush/busy=%b cnt=%0d expected 000/2", {redirect_valid, flush, busy}, mispredict_cnt);
      end
      step();
      drive_ex(0, 0, 0, 0, 32'h0, 32'h0);
      vectors++;
      if ({redirect_valid, busy} !== 2'b00 || mispredict_cnt !== 16'd2) begin
         miscompares++;
         $display("FAIL ex_invalid rv/busy=%b cnt=%0d expected 00/2", {redirect_valid, busy}, mispredict_cnt);
      end
   endtask

   task automatic test_back_to_back();
      drive_ex(1, 1, 1, 0, 32'h204, 32'h200);
      step();
      vectors++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200 || mispredict_cnt !== 16'd3) begin
         miscompares++;
         $display("FAIL b2b_first rv=%b pc=%h cnt=%0d expected 1/00000200/3", redirect_valid, redirect_pc, mispredict_cnt);
      end
      ex_target = 32'h300;
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (redirect_valid !== 1'b0 || flush !== 1'b0 || mispredict_cnt !== 16'd3 || redirect_pc !== 32'h200) begin
            miscompares++;
            $display("FAIL b2b_drop cycle %0d rv=%b flush=%b cnt=%0d pc=%h expected 0/0/3/00000200",
                     i, redirect_valid, flush, mispredict_cnt, redirect_pc);
         end
      end
      drive_ex(0, 0, 0, 0, 32'h0, 32'h0);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_idle busy=%b expected 0", busy);
      end
   endtask

   task automatic test_predictor();
      logic exp_pred [5];
      logic tk_seq [4];
      do_reset();
      exp_pred = PRED_EN ? '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0} : '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tk_seq = '{1'b1, 1'b1, 1'b0, 1'b0};
      if_valid = 1'b1; if_pc = 32'h40;
      for (int i = 0; i < 5; i++) begin
         #1;
         vectors++;
         if (pred_taken !== exp_pred[i]) begin
            miscompares++;
            $display("FAIL bht_pred step %0d pred_taken=%b expected %b", i, pred_taken, exp_pred[i]);
         end
         if (i < 4) begin
            drive_ex(1, 1, tk_seq[i], tk_seq[i], 32'h40, 32'h80);
            #1;
            vectors++;
            if (pred_taken !== exp_pred[i]) begin
               miscompares++;
               $display("FAIL bht_same_cycle step %0d pred_taken=%b expected %b", i, pred_taken, exp_pred[i]);
            end
            step();
            drive_ex(0, 0, 0, 0, 32'h0, 32'h0);
         end
      end
      if_valid = 1'b0;
      #1;
      vectors++;
      if (pred_taken !== 1'b0) begin
         miscompares++;
         $display("FAIL bht_if_invalid pred_taken=%b expected 0", pred_taken);
      end
   endtask

   task automatic test_reset_mid_redirect();
      // idx 0 counter sits at 01 here; this taken resolve raises it to 10 before reset
      drive_ex(1, 1, 1, 0, 32'h40, 32'h900);
      step();
      drive_ex(0, 0, 0, 0, 32'h0, 32'h0);
      if_valid = 1'b1; if_pc = 32'h40;
      #1;
      vectors++;
      if (redirect_valid !== 1'b1 || busy !== 1'b1 || pred_taken !== PRED_EN) begin
         miscompares++;
         $display("FAIL pre_reset rv=%b busy=%b pred=%b expected 1/1/%b", redirect_valid, busy, pred_taken, PRED_EN);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if ({redirect_valid, flush, busy} !== 3'b000 || mispredict_cnt !== 16'd0) begin
         miscompares++;
         $display("FAIL mid_reset rv/flush/busy=%b cnt=%0d expected 000/0", {redirect_valid, flush, busy}, mispredict_cnt);
      end
      for (int i = 0; i < 16; i++) begin
         if_pc = 32'(i) << 2;
         #0.1;
         vectors++;
         if (pred_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_bht idx %0d pred_taken=%b expected 0", i, pred_taken);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      step();
      vectors++;
      if ({redirect_valid, flush, busy} !== 3'b000) begin
         miscompares++;
         $display("FAIL post_reset rv/flush/busy=%b expected 000", {redirect_valid, flush, busy});
      end
      if_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_mispredict_taken();
      test_wrap();
      test_correct_predict();
      test_back_to_back();
      test_predictor();
      test_reset_mid_redirect();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
